// File: rtl/dds_pkg.sv
// Shared constants and the quarter-wave sine table for the dds_wavegen oscillator.
package dds_pkg;

    localparam int unsigned PHASE_W    = 32;
    localparam int unsigned OUT_W      = 12;
    localparam int unsigned LUT_ADDR_W = 8;
    localparam int unsigned LUT_DEPTH  = 1 << LUT_ADDR_W;
    localparam int unsigned LUT_DATA_W = 11;
    localparam int unsigned MIDSCALE   = 2048;
    localparam int unsigned QTAB_BITS  = LUT_DEPTH * LUT_DATA_W;

    typedef enum logic [1:0] {
        Q0_POS_RISE = 2'd0,
        Q1_POS_FALL = 2'd1,
        Q2_NEG_FALL = 2'd2,
        Q3_NEG_RISE = 2'd3
    } quadrant_e;

    // Q[i] = round(2047 * sin(pi*(2i+1)/1024)), built at elaboration with a
    // Q2.30 fixed-point Taylor series so no real arithmetic reaches synthesis.
    function automatic logic [QTAB_BITS-1:0] build_qtab();
        logic [QTAB_BITS-1:0] tab;
        longint pi_q30;
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint q;
        tab    = '0;
        pi_q30 = 64'sd3373259426;
        for (int unsigned i = 0; i < LUT_DEPTH; i++) begin
            x    = (pi_q30 * longint'(2 * i + 1)) / 64'sd1024;
            x2   = (x * x) >>> 30;
            term = x;
            sum  = x;
            for (int unsigned k = 1; k <= 8; k++) begin
                term = -(term * x2) / longint'((2 * k) * (2 * k + 1));
                term = term >>> 30;
                sum  = sum + term;
            end
            q = (64'sd2047 * sum + (64'sd1 <<< 29)) >>> 30;
            tab[i*LUT_DATA_W +: LUT_DATA_W] = q[LUT_DATA_W-1:0];
        end
        return tab;
    endfunction

    localparam logic [QTAB_BITS-1:0] QTAB = build_qtab();

endpackage

// File: rtl/dds_wavegen_if.sv
// Tuning-word inputs and waveform outputs of the dds_wavegen oscillator.
interface dds_wavegen_if #(
    parameter int unsigned PHASE_WIDTH  = dds_pkg::PHASE_W,
    parameter int unsigned OUTPUT_WIDTH = dds_pkg::OUT_W
);
    logic [PHASE_WIDTH-1:0]  Fre_word;
    logic [PHASE_WIDTH-1:0]  Pha_word;
    logic [OUTPUT_WIDTH-1:0] wave_out_sin;
    logic [OUTPUT_WIDTH-1:0] wave_out_tri;
    logic [OUTPUT_WIDTH-1:0] wave_out_saw;

    modport master (
        output Fre_word, Pha_word,
        input  wave_out_sin, wave_out_tri, wave_out_saw
    );

    modport slave (
        input  Fre_word, Pha_word,
        output wave_out_sin, wave_out_tri, wave_out_saw
    );
endinterface

// File: rtl/dds_sine_lut.sv
// Combinational quarter-wave sine lookup with quadrant mirroring; offset-binary output.
module dds_sine_lut
    import dds_pkg::*;
(
    input  logic [LUT_ADDR_W+1:0] phase,
    output logic [OUT_W-1:0]      sine
);

    quadrant_e               quad;
    logic [LUT_ADDR_W-1:0]   idx;
    logic [LUT_ADDR_W-1:0]   addr;
    logic [LUT_DATA_W-1:0]   mag;
    logic                    negative;

    always_comb begin
        quad     = quadrant_e'(phase[LUT_ADDR_W+1:LUT_ADDR_W]);
        idx      = phase[LUT_ADDR_W-1:0];
        // Falling quadrants walk the table backwards.
        addr     = (quad == Q1_POS_FALL || quad == Q3_NEG_RISE) ? ~idx : idx;
        mag      = QTAB[int'(addr)*LUT_DATA_W +: LUT_DATA_W];
        negative = (quad == Q2_NEG_FALL || quad == Q3_NEG_RISE);
        if (negative) begin
            sine = OUT_W'(MIDSCALE - 1) - {1'b0, mag};
        end else begin
            sine = OUT_W'(MIDSCALE) + {1'b0, mag};
        end
    end

endmodule

// File: rtl/dds_wavegen.sv
// Phase accumulator with offset, driving registered sine, triangle and sawtooth outputs.
module dds_wavegen
    import dds_pkg::*;
#(
    parameter int unsigned OUTPUT_WIDTH = OUT_W,
    parameter int unsigned PHASE_WIDTH  = PHASE_W
) (
    input  logic          clock,
    input  logic          reset,
    dds_wavegen_if.slave  bus
);

    logic [PHASE_WIDTH-1:0]  acc_q, acc_d;
    logic [PHASE_WIDTH-1:0]  phase_q, phase_d;
    logic [OUTPUT_WIDTH-1:0] sin_q, sin_d;
    logic [OUTPUT_WIDTH-1:0] tri_q, tri_d;
    logic [OUTPUT_WIDTH-1:0] saw_q, saw_d;
    logic [OUTPUT_WIDTH-1:0] sine_lut;
    logic                    unused_phase_lsbs;

    dds_sine_lut u_sine (
        .phase (phase_q[PHASE_WIDTH-1 -: LUT_ADDR_W+2]),
        .sine  (sine_lut)
    );

    always_comb begin
        acc_d   = acc_q + bus.Fre_word;
        phase_d = acc_q + bus.Pha_word;
        saw_d   = phase_q[PHASE_WIDTH-1 -: OUTPUT_WIDTH];
        // 4095 - t is the bitwise complement of t for a 12-bit t.
        tri_d   = phase_q[PHASE_WIDTH-1] ? ~phase_q[PHASE_WIDTH-2 -: OUTPUT_WIDTH]
                                         :  phase_q[PHASE_WIDTH-2 -: OUTPUT_WIDTH];
        sin_d   = sine_lut;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q   <= '0;
            phase_q <= '0;
            sin_q   <= OUTPUT_WIDTH'(MIDSCALE);
            tri_q   <= '0;
            saw_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            phase_q <= phase_d;
            sin_q   <= sin_d;
            tri_q   <= tri_d;
            saw_q   <= saw_d;
        end
    end

    always_comb begin
        bus.wave_out_sin = sin_q;
        bus.wave_out_tri = tri_q;
        bus.wave_out_saw = saw_q;
    end

    assign unused_phase_lsbs = ^phase_q[PHASE_WIDTH-OUTPUT_WIDTH-2:0];

endmodule

// File: tb/tb_dds_wavegen.sv
// Self-checking bench for dds_wavegen: real-valued waveform model plus directed literal checks.
module tb_dds_wavegen;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;

    dds_wavegen_if bus ();

    dds_wavegen #(.OUTPUT_WIDTH(12), .PHASE_WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int exp_saw(input logic [31:0] ph);
        return int'(ph / 32'd1048576);
    endfunction

    // Rising half counts up in 2^19 steps, falling half counts down to 0.
    function automatic int exp_tri(input logic [31:0] ph);
        if (ph < 32'h8000_0000) return int'(ph / 32'd524288);
        return int'((32'hFFFF_FFFF - ph) / 32'd524288);
    endfunction

    // Sine sampled at the centre of each of 1024 phase bins.
    function automatic int exp_sin(input logic [31:0] ph);
        real ang;
        real s;
        int  bin;
        bin = int'(ph / 32'd4194304);
        ang = 2.0 * 3.14159265358979323846 * (real'(bin) + 0.5) / 1024.0;
        s   = $sin(ang);
        if (s >= 0.0) return 2048 + $rtoi(2047.0 * s + 0.5);
        return 2047 - $rtoi(-2047.0 * s + 0.5);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase captured at an edge is shown on the outputs one edge later.
    logic [31:0] m_acc;
    logic [31:0] m_phase;
    int          e_sin, e_tri, e_saw;
    bit          armed;

    initial begin
        armed = 1'b0;
        m_acc = '0;
        m_phase = '0;
        e_sin = 0;
        e_tri = 0;
        e_saw = 0;
    end

    always @(posedge clock) begin
        if (reset) begin
            e_sin   = 2048;
            e_tri   = 0;
            e_saw   = 0;
            m_acc   = '0;
            m_phase = '0;
            armed   = 1'b1;
        end else begin
            e_sin   = exp_sin(m_phase);
            e_tri   = exp_tri(m_phase);
            e_saw   = exp_saw(m_phase);
            m_phase = m_acc + bus.Pha_word;
            m_acc   = m_acc + bus.Fre_word;
        end
    end

    always @(negedge clock) begin
        if (armed) begin
            chk("model_sin", int'(bus.wave_out_sin), e_sin);
            chk("model_tri", int'(bus.wave_out_tri), e_tri);
            chk("model_saw", int'(bus.wave_out_saw), e_saw);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_reset(input logic [31:0] fre, input logic [31:0] pha);
        reset = 1'b1;
        bus.Fre_word = fre;
        bus.Pha_word = pha;
        step(1);
        reset = 1'b0;
    endtask

    logic [31:0] pha_steps [4];
    int          sin_lits  [4];
    int          tri_lits  [4];
    logic [31:0] vec_fre   [6];
    logic [31:0] vec_pha   [6];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        pha_steps = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
        sin_lits  = '{2054, 4095, 2041, 0};
        tri_lits  = '{0, 2048, 4095, 2047};
        vec_fre   = '{32'h0123_4567, 32'h8000_0001, 32'h0000_0000,
                      32'hF000_0000, 32'h0040_0000, 32'h7FFF_FFFF};
        vec_pha   = '{32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF,
                      32'h3FFF_FFFF, 32'hBFC0_0000, 32'h8000_0000};

        // Pin the model against hand-derived waveform values.
        for (int i = 0; i < 4; i++) begin
            chk("model_pin_sin", exp_sin(pha_steps[i]), sin_lits[i]);
            chk("model_pin_tri", exp_tri(pha_steps[i]), tri_lits[i]);
        end
        chk("model_pin_saw", exp_saw(32'hFFFF_FFFF), 4095);

        // Reset held for two edges with a running tuning word.
        reset = 1'b1;
        bus.Fre_word = 32'h1000_0000;
        bus.Pha_word = 32'h0;
        step(2);
        chk("reset_sin", int'(bus.wave_out_sin), 2048);
        chk("reset_tri", int'(bus.wave_out_tri), 0);
        chk("reset_saw", int'(bus.wave_out_saw), 0);

        // Ramp: saw 0,0,256,... after release.
        reset = 1'b0;
        step(3);
        chk("ramp_saw", int'(bus.wave_out_saw), 256);
        chk("ramp_tri", int'(bus.wave_out_tri), 512);
        step(37);

        // Static phase offsets with zero frequency.
        pulse_reset(32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus.Pha_word = pha_steps[i];
            step(2);
            chk("offset_sin", int'(bus.wave_out_sin), sin_lits[i]);
            chk("offset_tri", int'(bus.wave_out_tri), tri_lits[i]);
            step(2);
        end

        // Maximum tuning word and offset: phase counts down from 0xFFFFFFFF.
        pulse_reset(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step(2);
        chk("max_saw", int'(bus.wave_out_saw), 4095);
        chk("max_sin", int'(bus.wave_out_sin), 2041);
        chk("max_tri", int'(bus.wave_out_tri), 0);
        step(30);

        // Decrementing phase across the zero boundary.
        pulse_reset(32'hFFFF_FFFF, 32'h0);
        step(3);
        chk("wrap_saw", int'(bus.wave_out_saw), 4095);
        step(10);

        // Frequency dropped to zero after five steps freezes the phase at 0x50000000.
        pulse_reset(32'h1000_0000, 32'h0);
        step(5);
        bus.Fre_word = 32'h0;
        step(8);
        chk("freeze_saw", int'(bus.wave_out_saw), 1280);
        chk("freeze_tri", int'(bus.wave_out_tri), 2560);
        step(10);

        // Reset pulse in the middle of a run.
        bus.Fre_word = 32'h3000_0000;
        bus.Pha_word = 32'h2000_0000;
        step(10);
        reset = 1'b1;
        step(1);
        chk("midrst_sin", int'(bus.wave_out_sin), 2048);
        chk("midrst_tri", int'(bus.wave_out_tri), 0);
        chk("midrst_saw", int'(bus.wave_out_saw), 0);
        reset = 1'b0;
        step(1);
        chk("resume0_sin", int'(bus.wave_out_sin), 2054);
        chk("resume0_saw", int'(bus.wave_out_saw), 0);
        step(1);
        chk("resume1_saw", int'(bus.wave_out_saw), 512);
        chk("resume1_tri", int'(bus.wave_out_tri), 1024);
        step(10);

        // Words changing every few cycles; the model carries the checks.
        for (int i = 0; i < 6; i++) begin
            bus.Fre_word = vec_fre[i];
            bus.Pha_word = vec_pha[i];
            step(3);
        end
        for (int i = 0; i < 12; i++) begin
            bus.Fre_word = vec_fre[i % 6] ^ 32'h0F0F_0F0F;
            bus.Pha_word = vec_pha[(i + 3) % 6];
            step(1);
        end
        step(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
